// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle mult/div ops with a
// latency counter, and applies MTHI/MTLO/SHL in a single cycle when idle.
module mdu_hilo #(
  parameter int DW    = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       MDUOP,
  input  logic [CNT_W-1:0] Time,
  input  logic [DW-1:0]    A,
  input  logic [DW-1:0]    B,
  input  logic [1:0]       ReadHILO,
  output logic             Busy,
  output logic [DW-1:0]    Out
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_SHL   = 4'b1000;

  logic [DW-1:0]    hi, lo, a_q, b_q;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt;

  logic             is_md;
  logic [3:0]       op;
  logic [DW-1:0]    opa, opb;
  logic [2*DW-1:0]  prod_s, prod_u;
  logic             div_s, na, nb;
  logic [DW-1:0]    da, db, qu, ru, quo, rem;
  logic             res_wr;
  logic [DW-1:0]    res_hi, res_lo;

  assign is_md = (MDUOP == OP_MULT) || (MDUOP == OP_MULTU) ||
                 (MDUOP == OP_DIV)  || (MDUOP == OP_DIVU);

  // Latched operands while in flight; live operands for a zero-latency start.
  assign op  = Busy ? op_q : MDUOP;
  assign opa = Busy ? a_q  : A;
  assign opb = Busy ? b_q  : B;

  // Sign-extended full-width multiply: the low 2*DW bits are the signed product.
  assign prod_s = {{DW{opa[DW-1]}}, opa} * {{DW{opb[DW-1]}}, opb};
  assign prod_u = {{DW{1'b0}}, opa} * {{DW{1'b0}}, opb};

  // Signed divide via magnitudes; MIN/-1 falls out as quotient MIN, remainder 0.
  assign div_s = (op == OP_DIV);
  assign na    = div_s & opa[DW-1];
  assign nb    = div_s & opb[DW-1];
  assign da    = na ? -opa : opa;
  assign db    = nb ? -opb : opb;
  assign qu    = (db == '0) ? '0 : da / db;
  assign ru    = (db == '0) ? '0 : da % db;
  assign quo   = (na ^ nb) ? -qu : qu;
  assign rem   = na ? -ru : ru;

  always_comb begin
    res_wr = 1'b0;
    res_hi = hi;
    res_lo = lo;
    case (op)
      OP_MULT:  begin res_wr = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin res_wr = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV, OP_DIVU: begin
        res_wr = (opb != '0);
        res_hi = rem;
        res_lo = quo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      cnt  <= '0;
      Busy <= 1'b0;
    end else if (Busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        Busy <= 1'b0;
        cnt  <= '0;
        if (res_wr) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end else if (Start && is_md) begin
      if (Time != '0) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= MDUOP;
        cnt  <= Time;
        Busy <= 1'b1;
      end else if (res_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      case (MDUOP)
        OP_MTHI: hi <= A;
        OP_MTLO: lo <= A;
        OP_SHL:  {hi, lo} <= {hi[DW-2:0], lo, 1'b0};
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ReadHILO)
      2'b10:   Out = hi;
      2'b01:   Out = lo;
      default: Out = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: the driver pushes expected Busy lengths and HI/LO
// reads computed by a plain-arithmetic model; a negedge monitor pops and compares.
module tb_mdu_hilo;
  localparam int DW    = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, Start;
  logic [3:0]       MDUOP;
  logic [CNT_W-1:0] Time;
  logic [DW-1:0]    A, B;
  logic [1:0]       ReadHILO;
  logic             Busy;
  logic [DW-1:0]    Out;

  always #5 clk = ~clk;

  mdu_hilo #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOP(MDUOP), .Time(Time),
    .A(A), .B(B), .ReadHILO(ReadHILO), .Busy(Busy), .Out(Out)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi, m_lo;
  int          busy_q[$];
  logic [31:0] rd_q[$];
  bit          rd_chk = 1'b0;
  int          busy_len = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: checks Busy run lengths and every HI/LO read the driver announces.
  always @(negedge clk) begin
    if (reset) busy_len = 0;
    else if (Busy === 1'b1) busy_len++;
    else if (busy_len != 0) begin
      if (busy_q.size() == 0) chk("busy_unexpected", busy_len, 0);
      else chk("busy_len", busy_len, busy_q.pop_front());
      busy_len = 0;
    end
    if (rd_chk) begin
      if (rd_q.size() == 0) chk("out_no_expect", Out, 32'hxxxxxxxx);
      else chk("out", Out, rd_q.pop_front());
    end
  end

  // Reference: architectural HI/LO semantics with native arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    case (op)
      4'd1: begin p = longint'(int'(a)) * longint'(int'(b)); {m_hi, m_lo} = p; end
      4'd2: begin u = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = u; end
      4'd3: if (b != 0) begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          m_lo = 32'h80000000; m_hi = 32'h0;
        end else begin
          m_lo = int'(a) / int'(b);
          m_hi = int'(a) % int'(b);
        end
      end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      4'd8: {m_hi, m_lo} = {m_hi, m_lo} << 1;
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int t);
    Start = 1'b1; MDUOP = op; Time = t[CNT_W-1:0]; A = a; B = b;
    if (t > 0) busy_q.push_back(t);
    model(op, a, b);
    step();
    Start = 1'b0; MDUOP = 4'd0; Time = '0;
    // Scramble every input while busy: none of it may affect the result.
    for (int k = 0; k < 40 && Busy === 1'b1; k++) begin
      A = $urandom; B = $urandom; Start = 1'($urandom_range(0, 1)); Time = 4'd5;
      case ($urandom_range(0, 3))
        0: MDUOP = 4'd5;
        1: MDUOP = 4'd6;
        2: MDUOP = 4'd8;
        default: MDUOP = 4'd1;
      endcase
      step();
    end
    Start = 1'b0; MDUOP = 4'd0; Time = '0;
    if (Busy !== 1'b0) chk("busy_timeout", 32'(Busy), 0);
  endtask

  task automatic sop(input logic [3:0] op, input logic [31:0] a);
    MDUOP = op; A = a;
    model(op, a, 32'd0);
    step();
    MDUOP = 4'd0;
  endtask

  task automatic check_hilo();
    rd_chk = 1'b1;
    ReadHILO = 2'b10; rd_q.push_back(m_hi); step();
    ReadHILO = 2'b01; rd_q.push_back(m_lo); step();
    ReadHILO = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11; rd_q.push_back(32'd0); step();
    rd_chk = 1'b0;
    ReadHILO = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          t;
    reset = 1'b1; Start = 1'b0; MDUOP = 4'd0; Time = '0; A = '0; B = '0; ReadHILO = 2'b10;
    m_hi = '0; m_lo = '0;
    step(); step();
    chk("reset_busy", 32'(Busy), 0);
    chk("reset_out_hi", Out, 0);
    reset = 1'b0;
    check_hilo();

    md(4'd1, 32'hFFFFFFFD, 32'd5, 5);      check_hilo();
    md(4'd4, 32'd7, 32'd2, 10);            check_hilo();
    md(4'd3, 32'hFFFFFFF9, 32'd2, 10);     check_hilo();
    md(4'd3, 32'h80000000, 32'hFFFFFFFF, 10); check_hilo();
    sop(4'd5, 32'h11); sop(4'd6, 32'h22);
    md(4'd3, 32'h12345678, 32'd0, 10);     check_hilo();
    md(4'd4, 32'h12345678, 32'd0, 10);     check_hilo();
    sop(4'd5, 32'h80000001); sop(4'd6, 32'h80000000); sop(4'd8, 32'd0);
    check_hilo();

    // Asynchronous reset three cycles into a MULT.
    Start = 1'b1; MDUOP = 4'd1; Time = 4'd5; A = $urandom; B = $urandom;
    step();
    Start = 1'b0; MDUOP = 4'd0; Time = '0;
    step(); step();
    #2 reset = 1'b1;
    #1 chk("midreset_busy", 32'(Busy), 0);
    ReadHILO = 2'b10;
    #1 chk("midreset_hi", Out, 0);
    ReadHILO = 2'b01;
    #1 chk("midreset_lo", Out, 0);
    ReadHILO = 2'b00;
    m_hi = '0; m_lo = '0;
    step();
    reset = 1'b0;
    check_hilo();
    md(4'd1, 32'h00012345, 32'hFFFF0001, 5); check_hilo();

    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 9);
      case ($urandom_range(0, 7))
        0, 1, 2, 3: begin
          op = 4'($urandom_range(1, 4));
          if (op >= 4'd3 && $urandom_range(0, 7) == 0) b = 32'd0;
          t = ($urandom_range(0, 3) == 0) ? 0 : ((op <= 4'd2) ? 5 : 10);
          md(op, a, b, t);
        end
        4: sop(4'd5, a);
        5: sop(4'd6, a);
        6: sop(4'd8, a);
        default: begin
          MDUOP = ($urandom_range(0, 1) == 0) ? 4'd15 : 4'd0;
          A = a; B = b;
          step();
          MDUOP = 4'd0;
        end
      endcase
      check_hilo();
    end

    step(); step();
    chk("busy_q_left", busy_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
